// File: rtl/data_mem_responder.sv
// Word-addressed data memory for a pipeline MEM stage: one request in flight,
// fixed LATENCY wait cycles, then a single-cycle response with error flagging.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic          acc_err;

    // Upper address bits must be zero so that e.g. 0x100 never aliases word 0.
    assign word_idx = addr_q[AW+1:2];
    assign acc_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

    assign req_ready = (state_q == IDLE);
    assign stall     = req_valid && !req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge values of the registers it reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            // NOTE: storage is built from flops with a reset-time clear, which
            // rules out a RAM macro; a reset must leave every word at zero.
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        if (acc_err || write_q) begin
                            rsp_rdata_q <= '0;
                        end else begin
                            rsp_rdata_q <= mem_q[word_idx];
                        end
                        if (!acc_err && write_q) begin
                            mem_q[word_idx] <= wdata_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=2, DEPTH_WORDS=64): latency,
// error decode, aliasing, back-to-back stall behaviour and reset abort.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(
        .DEPTH_WORDS(64),
        .LATENCY    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request from IDLE, scrambles req_* after acceptance and returns
    // the response plus the cycle index (1 = cycle right after acceptance) of rsp_valid.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic err, output int lat);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = ~d;
        lat   = 0;
        rdata = 32'hX;
        err   = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        check("stall_idle", {31'd0, stall}, 32'd0);

        // Store then load of the same word
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        check("st10_latency", 32'(lat), 32'd3);
        check("st10_err", {31'd0, er}, 32'd0);
        check("st10_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
        check("ld10_latency", 32'(lat), 32'd3);
        check("ld10_rdata", rd, 32'hDEAD_BEEF);
        check("ld10_err", {31'd0, er}, 32'd0);
        #1;
        check("rsp_valid_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check("rdata_held", rsp_rdata, 32'hDEAD_BEEF);

        // Misaligned and out-of-range accesses
        do_req(1'b0, 32'h13, 32'h0, rd, er, lat);
        check("ld13_err", {31'd0, er}, 32'd1);
        check("ld13_rdata", rd, 32'd0);
        do_req(1'b1, 32'h102, 32'h1, rd, er, lat);
        check("st102_err", {31'd0, er}, 32'd1);
        check("st102_latency", 32'(lat), 32'd3);
        do_req(1'b0, 32'h100, 32'h0, rd, er, lat);
        check("ld100_err", {31'd0, er}, 32'd1);
        check("ld100_rdata", rd, 32'd0);
        do_req(1'b1, 32'h100, 32'h1234_5678, rd, er, lat);
        check("st100_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 32'h0, 32'h0, rd, er, lat);
        check("ld0_no_alias", rd, 32'd0);
        check("ld0_err", {31'd0, er}, 32'd0);
        do_req(1'b0, 32'h8000_0010, 32'h0, rd, er, lat);
        check("ld_high_bit_err", {31'd0, er}, 32'd1);

        // Last word
        do_req(1'b1, 32'hFC, 32'hA5A5_A5A5, rd, er, lat);
        check("stFC_err", {31'd0, er}, 32'd0);
        do_req(1'b0, 32'hFC, 32'h0, rd, er, lat);
        check("ldFC_rdata", rd, 32'hA5A5_A5A5);
        check("ldFC_err", {31'd0, er}, 32'd0);

        // Back-to-back with req_valid held high; address change during WAIT ignored
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h77;
        #1;
        check("b2b_stall_idle", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        req_addr  = 32'h44;
        req_wdata = 32'h99;
        #1;
        check("b2b_stall_wait1", {31'd0, stall}, 32'd1);
        @(posedge clk); #2;
        check("b2b_stall_wait2", {31'd0, stall}, 32'd1);
        check("b2b_ready_wait2", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #2;
        check("b2b_stall_resp", {31'd0, stall}, 32'd1);
        check("b2b_rsp_valid1", {31'd0, rsp_valid}, 32'd1);
        req_write = 1'b0;
        req_addr  = 32'h40;
        @(posedge clk); #2;
        check("b2b_ready_after_resp", {31'd0, req_ready}, 32'd1);
        check("b2b_stall_after_resp", {31'd0, stall}, 32'd0);
        check("b2b_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        check("b2b_second_accepted", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #2;
        check("b2b_ld_not_yet", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #2;
        check("b2b_ld_valid", {31'd0, rsp_valid}, 32'd1);
        check("b2b_ld_rdata", rsp_rdata, 32'h77);
        @(posedge clk); #1;
        do_req(1'b0, 32'h44, 32'h0, rd, er, lat);
        check("ld44_untouched", rd, 32'd0);

        // Reset during the last WAIT cycle aborts the store and clears storage
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_wait_rsp_valid_a", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("rst_wait_rsp_valid_b", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset2", {31'd0, req_ready}, 32'd1);
        do_req(1'b0, 32'h20, 32'h0, rd, er, lat);
        check("ld20_aborted", rd, 32'd0);
        check("ld20_err", {31'd0, er}, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
        check("ld10_cleared", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, SHALL set the number of 32-bit storage words (power of two, 4..1024).
REQ-002 Parameter LATENCY, default 2, SHALL set the number of WAIT cycles between request acceptance and response (1..15).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port req_valid  input  1  SHALL indicate that the pipeline MEM stage presents a load or store request.
REQ-006 Port req_write  input  1  SHALL select store (1) or load (0).
REQ-007 Port req_addr  input  32  SHALL carry the byte address (ALU result).
REQ-008 Port req_wdata  input  32  SHALL carry the store data.
REQ-009 Port req_ready  output  1  SHALL indicate that the block can accept a request this cycle.
REQ-010 Port rsp_valid  output  1  SHALL pulse for one cycle when a request completes.
REQ-011 Port rsp_rdata  output  32  SHALL carry the load data.
REQ-012 Port rsp_err  output  1  SHALL flag a misaligned or out-of-range access, valid while rsp_valid=1.
REQ-013 Port stall  output  1  SHALL request a pipeline freeze; stall = req_valid AND NOT req_ready, combinational.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: when req_valid=1, the block SHALL latch req_write, req_addr and req_wdata, load the wait counter with LATENCY-1 and go to WAIT; otherwise it SHALL stay in IDLE.
REQ-016 WAIT: the counter SHALL decrement each cycle; at counter=0 the FSM SHALL go to RESP. WAIT therefore lasts exactly LATENCY cycles.
REQ-017 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE. No request SHALL be accepted in RESP.
REQ-018 Request-to-response latency: if accepted at edge N, rsp_valid SHALL be 1 in the cycle after edge N+LATENCY. Throughput is one request per LATENCY+2 cycles.
REQ-019 Word index = latched addr[log2(DEPTH_WORDS)+1:2]; the access is in range if and only if addr[31:log2(DEPTH_WORDS)+2] = 0.
REQ-020 Misaligned (addr[1:0] != 0) or out-of-range access: rsp_err=1, rsp_rdata=0, no storage write.
REQ-021 Valid store: the storage word SHALL be written on the WAIT-to-RESP edge; rsp_rdata=0, rsp_err=0.
REQ-022 Valid load: rsp_rdata SHALL be the storage word sampled on the WAIT-to-RESP edge, with rsp_err=0.
REQ-023 rsp_rdata and rsp_err SHALL hold their values after RESP until the next RESP.
REQ-024 Changes on req_* inputs after acceptance SHALL NOT affect the in-flight request.
REQ-025 A load following a store to the same word SHALL return the stored value (no bypass required, because accesses are serialised).
REQ-026 There SHALL be no byte or halfword access; all accesses are full 32-bit words.

Reset
REQ-027 While rst_n=0 at an edge: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and all storage words are cleared to 0.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the request; a pending store SHALL NOT be written.
REQ-029 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification (LATENCY=2, DEPTH_WORDS=64)
REQ-030 Store addr 0x10, data 0xDEADBEEF, then load 0x10 -> rsp_valid exactly 3 cycles after each acceptance edge; load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-031 Load 0x13 -> rsp_err=1, rsp_rdata=0; store 0x102 with data 0x1 -> rsp_err=1; a later load of 0x100 returns 0.
REQ-032 Load 0x100 (word 64, out of range) -> rsp_err=1; a store to 0x100 SHALL NOT alias word 0 (load 0x0 returns 0).
REQ-033 req_valid held high for back-to-back requests -> stall=1 in every WAIT and RESP cycle; second accepted in the cycle after RESP; req_addr change during WAIT ignored.
REQ-034 Store 0x20 = 0x55, with rst_n low in the WAIT cycle -> after reset, load 0x20 returns 0 and rsp_valid stayed 0 during reset.
REQ-035 Store 0xFC = 0xA5A5A5A5 (last word) then load 0xFC -> 0xA5A5A5A5, rsp_err=0.
